// File: rtl/text_console_writer.sv
`timescale 1ns/1ps
// text_console_writer
// Writer side of the text-mode screen RAM. It takes a stream of character
// bytes with per-character colours and writes 16-bit cells into the RAM
// write port. It also keeps the cursor and handles CR, LF, BS and FF.
// A row is cleared whenever the cursor moves onto it. The whole screen is
// cleared after reset and on form feed.
//
// Ports:
//   pixel_clock  - single clock, shared with the screen RAM write port
//   reset_n      - asynchronous active-low reset
//   char_data    - character or control code
//   char_fcolor  - foreground colour sampled with char_data
//   char_bcolor  - background colour sampled with char_data
//   char_valid   - char_data and colours are valid
//   char_ready   - a character is accepted this cycle when valid is also high
//   wraddress    - RAM write address {row[5:0], col[6:0]}
//   wrdata       - cell {1'b0, bcolor, 1'b0, fcolor, char}
//   wren         - write strobe, one cell per asserted cycle
//   cursor_row   - current cursor row
//   cursor_col   - current cursor column
module text_console_writer #(
    parameter int         COLS       = 90,
    parameter int         ROWS       = 56,
    parameter logic [2:0] CLR_FCOLOR = 3'd7,
    parameter logic [2:0] CLR_BCOLOR = 3'd1
) (
    input  logic        pixel_clock,
    input  logic        reset_n,
    input  logic [7:0]  char_data,
    input  logic [2:0]  char_fcolor,
    input  logic [2:0]  char_bcolor,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [12:0] wraddress,
    output logic [15:0] wrdata,
    output logic        wren,
    output logic [5:0]  cursor_row,
    output logic [6:0]  cursor_col
);

    typedef enum logic [1:0] {
        CLEAR_ALL  = 2'd0,
        IDLE       = 2'd1,
        CLEAR_LINE = 2'd2
    } state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_FF = 8'h0C;
    localparam logic [7:0] CODE_CR = 8'h0D;
    localparam logic [7:0] SPACE   = 8'h20;

    // Pack one screen cell in the layout the renderer expects.
    function automatic logic [15:0] make_cell(input logic [2:0] bc,
                                              input logic [2:0] fc,
                                              input logic [7:0] ch);
        return {1'b0, bc, 1'b0, fc, ch};
    endfunction

    localparam logic [15:0] CLR_CELL = {1'b0, CLR_BCOLOR, 1'b0, CLR_FCOLOR, SPACE};

    state_t      state_r, state_s;
    logic [5:0]  row_r, row_s, next_row_s;
    logic [6:0]  col_r, col_s;
    logic [5:0]  clr_row_r, clr_row_s;
    logic [6:0]  clr_col_r, clr_col_s;
    logic        wren_r, wren_s;
    logic [12:0] wraddr_r, wraddr_s;
    logic [15:0] wrdata_r, wrdata_s;
    logic        ready_r;

    // The row the cursor moves to on a line feed or a wrap. There is no scroll, so the last row wraps to row 0.
    assign next_row_s = (row_r == LAST_ROW) ? 6'd0 : row_r + 6'd1;

    // Next-state, cursor, clear-counter and write-port decode.
    always_comb begin
        state_s   = state_r;
        row_s     = row_r;
        col_s     = col_r;
        clr_row_s = clr_row_r;
        clr_col_s = clr_col_r;
        wren_s    = 1'b0;
        wraddr_s  = wraddr_r;
        wrdata_s  = wrdata_r;
        case (state_r)
            CLEAR_ALL: begin
                wren_s   = 1'b1;
                wraddr_s = {clr_row_r, clr_col_r};
                wrdata_s = CLR_CELL;
                if (clr_col_r == LAST_COL) begin
                    clr_col_s = 7'd0;
                    if (clr_row_r == LAST_ROW) begin
                        clr_row_s = 6'd0;
                        state_s   = IDLE;
                    end else begin
                        clr_row_s = clr_row_r + 6'd1;
                    end
                end else begin
                    clr_col_s = clr_col_r + 7'd1;
                end
            end
            CLEAR_LINE: begin
                wren_s   = 1'b1;
                wraddr_s = {clr_row_r, clr_col_r};
                wrdata_s = CLR_CELL;
                if (clr_col_r == LAST_COL) begin
                    clr_col_s = 7'd0;
                    state_s   = IDLE;
                end else begin
                    clr_col_s = clr_col_r + 7'd1;
                end
            end
            IDLE: begin
                if (char_valid) begin
                    case (char_data)
                        CODE_CR: begin
                            col_s = 7'd0;
                        end
                        CODE_LF: begin
                            col_s     = 7'd0;
                            row_s     = next_row_s;
                            clr_row_s = next_row_s;
                            clr_col_s = 7'd0;
                            state_s   = CLEAR_LINE;
                        end
                        CODE_BS: begin
                            if (col_r != 7'd0) begin
                                col_s    = col_r - 7'd1;
                                wren_s   = 1'b1;
                                wraddr_s = {row_r, col_r - 7'd1};
                                wrdata_s = make_cell(char_bcolor, char_fcolor, SPACE);
                            end else begin
                                col_s = col_r;
                            end
                        end
                        CODE_FF: begin
                            row_s     = 6'd0;
                            col_s     = 7'd0;
                            clr_row_s = 6'd0;
                            clr_col_s = 7'd0;
                            state_s   = CLEAR_ALL;
                        end
                        default: begin
                            wren_s   = 1'b1;
                            wraddr_s = {row_r, col_r};
                            wrdata_s = make_cell(char_bcolor, char_fcolor, char_data);
                            if (col_r != LAST_COL) begin
                                col_s = col_r + 7'd1;
                            end else begin
                                col_s     = 7'd0;
                                row_s     = next_row_s;
                                clr_row_s = next_row_s;
                                clr_col_s = 7'd0;
                                state_s   = CLEAR_LINE;
                            end
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s   = CLEAR_ALL;
                clr_row_s = 6'd0;
                clr_col_s = 7'd0;
            end
        endcase
    end

    // State, cursor and registered write-port outputs.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= CLEAR_ALL;
            row_r     <= 6'd0;
            col_r     <= 7'd0;
            clr_row_r <= 6'd0;
            clr_col_r <= 7'd0;
            wren_r    <= 1'b0;
            wraddr_r  <= 13'd0;
            wrdata_r  <= 16'd0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            row_r     <= row_s;
            col_r     <= col_s;
            clr_row_r <= clr_row_s;
            clr_col_r <= clr_col_s;
            wren_r    <= wren_s;
            wraddr_r  <= wraddr_s;
            wrdata_r  <= wrdata_s;
            ready_r   <= (state_s == IDLE);
        end
    end

    assign char_ready = ready_r;
    assign wren       = wren_r;
    assign wraddress  = wraddr_r;
    assign wrdata     = wrdata_r;
    assign cursor_row = row_r;
    assign cursor_col = col_r;

endmodule

// File: tb/tb_text_console_writer.sv
`timescale 1ns/1ps
// Bench for text_console_writer. A cursor/screen model works out, for each
// character sent, the expected cell write, the cursor afterwards and the
// clear sequence that follows. Random traffic is mixed with directed cases.
module tb_text_console_writer;

    localparam int COLS = 90;
    localparam int ROWS = 56;
    localparam int CLR  = 16'h1720;

    logic        pixel_clock;
    logic        reset_n;
    logic [7:0]  char_data;
    logic [2:0]  char_fcolor;
    logic [2:0]  char_bcolor;
    logic        char_valid;
    logic        char_ready;
    logic [12:0] wraddress;
    logic [15:0] wrdata;
    logic        wren;
    logic [5:0]  cursor_row;
    logic [6:0]  cursor_col;

    int n_checks = 0;
    int n_bad    = 0;
    int m_row    = 0;
    int m_col    = 0;

    text_console_writer dut (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .char_data   (char_data),
        .char_fcolor (char_fcolor),
        .char_bcolor (char_bcolor),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .wraddress   (wraddress),
        .wrdata      (wrdata),
        .wren        (wren),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col)
    );

    initial pixel_clock = 1'b0;
    always #5 pixel_clock = ~pixel_clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_cursor(input string tag);
        check_eq({tag, "_row"}, 32'(cursor_row), 32'(m_row));
        check_eq({tag, "_col"}, 32'(cursor_col), 32'(m_col));
    endtask

    // Full-screen clear: one write per cycle, row-major, every row and only the visible columns.
    task automatic expect_clear_all();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                @(posedge pixel_clock); #1;
                check_eq("clrall_wren", 32'(wren), 32'd1);
                check_eq("clrall_addr", 32'(wraddress), 32'(r * 128 + c));
                check_eq("clrall_data", 32'(wrdata), 32'(CLR));
                check_eq("clrall_ready", 32'(char_ready), 32'((r == ROWS - 1) && (c == COLS - 1)));
            end
        end
        check_cursor("clrall_cursor");
    endtask

    // Send one byte and check the result against the model. With stop_after > 0, the bench
    // follows only that many line-clear writes and returns in the middle of the clear.
    task automatic send(input logic [7:0] ch, input logic [2:0] fc, input logic [2:0] bc,
                        input int stop_after);
        int  n;
        bit  exp_wr;
        int  exp_addr;
        int  exp_data;
        bit  line_clr;
        bit  all_clr;
        int  nclr;
        n = 0;
        while (!char_ready && n < 10000) begin
            @(posedge pixel_clock); #1;
            n++;
        end
        if (!char_ready) begin
            check_eq("ready_timeout", 32'(char_ready), 32'd1);
            return;
        end
        char_data   = ch;
        char_fcolor = fc;
        char_bcolor = bc;
        char_valid  = 1'b1;
        @(posedge pixel_clock); #1;
        char_valid  = 1'b0;

        exp_wr   = 1'b0;
        exp_addr = 0;
        exp_data = 0;
        line_clr = 1'b0;
        all_clr  = 1'b0;
        case (ch)
            8'h0D: m_col = 0;
            8'h0A: begin
                m_col    = 0;
                m_row    = (m_row + 1) % ROWS;
                line_clr = 1'b1;
            end
            8'h08: begin
                if (m_col > 0) begin
                    m_col--;
                    exp_wr   = 1'b1;
                    exp_addr = m_row * 128 + m_col;
                    exp_data = (int'(bc) << 12) | (int'(fc) << 8) | 32'h20;
                end
            end
            8'h0C: begin
                m_row   = 0;
                m_col   = 0;
                all_clr = 1'b1;
            end
            default: begin
                exp_wr   = 1'b1;
                exp_addr = m_row * 128 + m_col;
                exp_data = (int'(bc) << 12) | (int'(fc) << 8) | int'(ch);
                if (m_col < COLS - 1) begin
                    m_col++;
                end else begin
                    m_col    = 0;
                    m_row    = (m_row + 1) % ROWS;
                    line_clr = 1'b1;
                end
            end
        endcase

        check_eq("char_wren", 32'(wren), 32'(exp_wr));
        if (exp_wr) begin
            check_eq("char_addr", 32'(wraddress), 32'(exp_addr));
            check_eq("char_data", 32'(wrdata), 32'(exp_data));
        end
        check_cursor("char_cursor");
        check_eq("char_ready", 32'(char_ready), 32'(!(line_clr || all_clr)));

        if (line_clr) begin
            nclr = (stop_after > 0) ? stop_after : COLS;
            for (int c = 0; c < nclr; c++) begin
                @(posedge pixel_clock); #1;
                check_eq("clrline_wren", 32'(wren), 32'd1);
                check_eq("clrline_addr", 32'(wraddress), 32'(m_row * 128 + c));
                check_eq("clrline_data", 32'(wrdata), 32'(CLR));
                check_eq("clrline_ready", 32'(char_ready), 32'(c == COLS - 1));
            end
        end
        if (all_clr) begin
            expect_clear_all();
        end
    endtask

    task automatic idle_cycle();
        @(posedge pixel_clock); #1;
        check_eq("idle_wren", 32'(wren), 32'd0);
        check_eq("idle_ready", 32'(char_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] rc;
        reset_n     = 1'b0;
        char_data   = 8'h00;
        char_fcolor = 3'd0;
        char_bcolor = 3'd0;
        char_valid  = 1'b0;
        repeat (3) @(posedge pixel_clock);
        #1;
        check_eq("rst_wren", 32'(wren), 32'd0);
        check_eq("rst_ready", 32'(char_ready), 32'd0);
        check_eq("rst_addr", 32'(wraddress), 32'd0);
        check_eq("rst_data", 32'(wrdata), 32'd0);
        check_cursor("rst_cursor");
        @(negedge pixel_clock);
        reset_n = 1'b1;
        expect_clear_all();
        idle_cycle();

        // 'A' in colour, then CR back to column 0
        send(8'h41, 3'd2, 3'd4, 0);
        check_eq("A_addr_const", 32'(wraddress), 32'h0000);
        check_eq("A_data_const", 32'(wrdata), 32'h4241);
        idle_cycle();
        send(8'h0D, 3'd0, 3'd0, 0);

        // a full row of printables, back to back, wraps and clears row 1
        for (int i = 0; i < COLS; i++) begin
            send(8'(8'h30 + (i % 40)), 3'(i), 3'(i + 3), 0);
        end
        check_eq("row_wrap_row", 32'(cursor_row), 32'd1);
        check_eq("row_wrap_col", 32'(cursor_col), 32'd0);
        idle_cycle();

        // walk to (55,7), then LF wraps to row 0
        for (int i = 0; i < ROWS - 2; i++) begin
            send(8'h0A, 3'd0, 3'd0, 0);
        end
        for (int i = 0; i < 7; i++) begin
            send(8'h61, 3'd5, 3'd2, 0);
        end
        check_eq("at55_row", 32'(cursor_row), 32'd55);
        send(8'h0A, 3'd0, 3'd0, 0);
        check_eq("wrap0_row", 32'(cursor_row), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send(8'h62, 3'd1, 3'd6, 0);
        end
        send(8'h0D, 3'd0, 3'd0, 0);
        idle_cycle();

        // backspace at column 0 and at column 5
        send(8'h0A, 3'd0, 3'd0, 0);
        send(8'h0A, 3'd0, 3'd0, 0);
        send(8'h08, 3'd3, 3'd3, 0);
        for (int i = 0; i < 5; i++) begin
            send(8'h63, 3'd4, 3'd4, 0);
        end
        send(8'h08, 3'd7, 3'd0, 0);
        check_eq("bs_addr_const", 32'(wraddress), 32'h0104);
        check_eq("bs_data_const", 32'(wrdata), 32'h0720);
        idle_cycle();

        // random traffic (form feed excluded here, tested below)
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                case ($urandom_range(2, 0))
                    0:       rc = 8'h0D;
                    1:       rc = 8'h0A;
                    default: rc = 8'h08;
                endcase
            end else begin
                rc = 8'($urandom_range(255, 0));
                if (rc == 8'h0C) begin
                    rc = 8'h2A;
                end
            end
            send(rc, 3'($urandom), 3'($urandom), 0);
            if ($urandom_range(3, 0) == 0) begin
                idle_cycle();
            end
        end

        // form feed clears the whole screen
        send(8'h0C, 3'd2, 3'd2, 0);
        idle_cycle();

        // reset in the middle of a line clear
        send(8'h0A, 3'd0, 3'd0, 40);
        reset_n = 1'b0;
        #1;
        m_row = 0;
        m_col = 0;
        check_eq("midrst_wren", 32'(wren), 32'd0);
        check_eq("midrst_ready", 32'(char_ready), 32'd0);
        check_eq("midrst_addr", 32'(wraddress), 32'd0);
        check_cursor("midrst_cursor");
        @(posedge pixel_clock);
        @(negedge pixel_clock);
        reset_n = 1'b1;
        expect_clear_all();
        idle_cycle();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1);
    end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Writer side of the text-mode screen memory. It accepts a stream of character bytes with per-character colours and writes 16-bit character cells into the screen RAM write port. The video sync/text renderer reads the same RAM on its read port and displays those cells. The block keeps a cursor, interprets a small set of control codes, clears rows as the cursor moves onto them, and clears the whole screen after reset and on form feed.

## Interface
- COLS, 90: visible text columns (1440/16); must be ≤ 128.
- ROWS, 56: visible text rows (900/16); must be ≤ 64.
- CLR_FCOLOR, 3'd7: foreground colour written by clear operations.
- CLR_BCOLOR, 3'd1: background colour written by clear operations.

Ports:
- pixel_clock  in  1  single clock, same clock as the screen RAM write port.
- reset_n  in  1  asynchronous, active-low reset.
- char_data  in  8  character code or control code.
- char_fcolor  in  3  foreground colour for char_data.
- char_bcolor  in  3  background colour for char_data.
- char_valid  in  1  char_data/colours valid.
- char_ready  out  1  block can accept a character this cycle.
- wraddress  out  13  screen RAM write address {row[5:0], col[6:0]}.
- wrdata  out  16  cell {1'b0, bcolor[2:0], 1'b0, fcolor[2:0], char[7:0]}.
- wren  out  1  write strobe, one cell per asserted cycle.
- cursor_row  out  6  current cursor row.
- cursor_col  out  7  current cursor column.

## Operation
- FSM states:
  - CLEAR_ALL: writes every cell, row-major, rows 0..ROWS-1 and cols 0..COLS-1 each. Columns ≥ COLS are never written. Then goes to IDLE.
  - IDLE: char_ready=1.
  - CLEAR_LINE: writes cols 0..COLS-1 of cursor_row, then goes to IDLE.
- Clear cell data is {1'b0, CLR_BCOLOR, 1'b0, CLR_FCOLOR, 8'h20}; defaults give 16'h1720.
- A transfer happens on a rising edge with char_valid & char_ready. Colours are sampled with char_data.
- Control codes:
  - 8'h0D (CR): col←0; no write.
  - 8'h0A (LF): row advance, col←0.
  - 8'h08 (BS): if col>0, col←col-1 and write space (8'h20) with the sampled colours at the new position. If col=0, no-op.
  - 8'h0C (FF): cursor←(0,0), enter CLEAR_ALL.
- Every other byte (including 8'h00..8'h1F not listed above) is printable:
  - write the cell at (row, col);
  - if col<COLS-1, col←col+1;
  - otherwise col←0 and row advance.
- Row advance: row←(row==ROWS-1) ? 0 : row+1, then enter CLEAR_LINE for the new row. There is no scrolling; wrap to row 0 is by design.
- Reset (any time, including mid-clear): outputs go to reset values immediately. After release, the block enters CLEAR_ALL with cursor (0,0).
- Reset values: wren=0, wraddress=0, wrdata=0, char_ready=0, cursor_row=0, cursor_col=0.

## Timing
- All outputs are registered; char_ready is a decode of the state register.
- Printable character or BS accepted at edge k: wren=1 with that cell's wraddress/wrdata during cycle k..k+1 (after edge k). Cursor updates at edge k.
- Line clear triggered at edge k: clear writes are registered at edges k+1..k+COLS, one address per cycle, col ascending. The last character write (if any) is at edge k.
  - char_ready=0 after edge k, back to 1 after edge k+COLS.
- CLEAR_ALL: ROWS*COLS consecutive write cycles with no gaps. char_ready rises after the last write edge.
  - After reset release, the first write is at the first rising edge.
  - After FF accepted at edge k, the first write is at edge k+1.
- char_ready=1 in IDLE, including when char_valid is held continuously. Back-to-back printables give one write per cycle.
- wren is 0 in any cycle with no scheduled write (CR, BS at col 0, IDLE without a transfer).
- char_valid while char_ready=0 is ignored. The source holds data until accepted.

## Test plan
- Reset release → 5040 consecutive wren cycles:
  - addresses 0x0000..0x0059, then 0x0080..0x00D9, …, last 0x1BD9;
  - all wrdata=0x1720;
  - no address with col ≥ 90 written;
  - then char_ready=1 and cursor (0,0).
- At (0,0), send 8'h41 with fcolor=2, bcolor=4 → next cycle wren=1, wraddress=0x0000, wrdata=0x4241; cursor (0,1); char_ready stays 1.
- 90 back-to-back printables from (0,0) → writes 0x0000..0x0059 on consecutive cycles, then 90 clear writes 0x0080..0x00D9 (data 0x1720) with char_ready=0, then cursor (1,0) and char_ready=1.
- Cursor (55,7), send LF → clear writes 0x0000..0x0059, cursor (0,0). Then send CR at (0,3) → no wren, cursor (0,0).
- BS at (2,0) → no write, cursor unchanged. BS at (2,5) with fcolor=7, bcolor=0 → write 0x0104 data 0x0720, cursor (2,4).
- Assert reset_n=0 during the 40th clear write of a CLEAR_LINE → wren drops without waiting for a clock, char_ready=0. After release, the full 5040-cycle clear restarts from 0x0000 and cursor is (0,0).
